// File: rtl/serial_add_ctrl_pkg.sv
// Shared types and constants for the bit-serial add/subtract controller.
package serial_add_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Two's-complement overflow from the carries entering and leaving the MSB.
  function automatic logic ovf_of(input logic carry_into_msb, input logic carry_out_msb);
    return carry_into_msb ^ carry_out_msb;
  endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Request/result bundle between a requester and the serial adder controller.
interface serial_add_ctrl_if #(
  parameter int WIDTH = serial_add_ctrl_pkg::DEFAULT_WIDTH
);

  logic             start;
  logic             sub;
  logic             cin;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, cin, op_a, op_b,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, sub, cin, op_a, op_b,
    output busy, done, sum, cout, ovf
  );

endinterface

// File: rtl/serial_add_ctrl_pfa_cell.sv
// One-bit partial full adder: sum plus generate/propagate; carry is resolved by the caller.
module pfa_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic g,
  output logic p
);

  assign s = a ^ b ^ c;
  assign g = a & b;
  assign p = a | b;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller: one operand bit per cycle, LSB first, through a single pfa_cell.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_add_ctrl_if.slave   bus
);

  localparam int                CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_carry;
  logic               r_sub;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-2:0]   r_acc;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;
  logic               r_ovf;
  logic               r_busy;
  logic               r_done;

  logic               w_b_eff;
  logic               w_s;
  logic               w_g;
  logic               w_p;
  logic               w_c_next;
  logic               w_last;
  logic [WIDTH-1:0]   w_acc_next;

  // Subtraction feeds the inverted B bit; the +1 comes from the initial carry.
  assign w_b_eff    = r_b[0] ^ r_sub;
  assign w_c_next   = w_g | (w_p & r_carry);
  assign w_last     = (r_cnt == CNT_LAST);
  assign w_acc_next = {w_s, r_acc};

  pfa_cell u_cell (
    .a (r_a[0]),
    .b (w_b_eff),
    .c (r_carry),
    .s (w_s),
    .g (w_g),
    .p (w_p)
  );

  // Controller FSM with operand/result datapath and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= {CNT_W{1'b0}};
      r_carry <= 1'b0;
      r_sub   <= 1'b0;
      r_a     <= {WIDTH{1'b0}};
      r_b     <= {WIDTH{1'b0}};
      r_acc   <= {(WIDTH-1){1'b0}};
      r_sum   <= {WIDTH{1'b0}};
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_a     <= bus.op_a;
            r_b     <= bus.op_b;
            r_sub   <= bus.sub;
            r_carry <= bus.sub ? 1'b1 : bus.cin;
            r_cnt   <= {CNT_W{1'b0}};
            r_acc   <= {(WIDTH-1){1'b0}};
            r_busy  <= 1'b1;
            r_state <= RUN;
          end else begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_a     <= {1'b0, r_a[WIDTH-1:1]};
          r_b     <= {1'b0, r_b[WIDTH-1:1]};
          r_acc   <= w_acc_next[WIDTH-1:1];
          r_carry <= w_c_next;
          // Results are published only on the final bit so sum stays stable while shifting.
          if (w_last) begin
            r_sum   <= w_acc_next;
            r_cout  <= w_c_next;
            r_ovf   <= ovf_of(r_carry, w_c_next);
            r_cnt   <= {CNT_W{1'b0}};
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_cnt   <= r_cnt + CNT_W'(1);
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_state <= RUN;
          end
        end
        default: begin
          r_cnt   <= {CNT_W{1'b0}};
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;
  assign bus.ovf  = r_ovf;

endmodule
